dcache_snoop_responder: RTL and testbench



---
 rtl/dcache_snoop_responder_pkg.sv | 39 +++
 rtl/dcache_snoop_responder_tag.sv | 43 ++++
 rtl/dcache_snoop_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_dcache_snoop_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_snoop_responder_pkg.sv
// Shared types for the dcache snoop responder.
//   msi_t          : MSI line state encoding used by the dcache state arrays.
//   snoop_state_t  : snoop responder FSM states.
//   IDX_LSB        : first address bit of the set index (above word and byte offsets).
//   downgrade()    : state a line is left in after a snoop hit.
package dcache_snoop_responder_pkg;

  localparam int IDX_W_DEFAULT = 3;
  localparam int TAG_W_DEFAULT = 25;
  localparam int BYTE_OFF_W    = 2;
  localparam int BLK_OFF_W     = 1;
  localparam int IDX_LSB       = BYTE_OFF_W + BLK_OFF_W;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_t;

  typedef enum logic [2:0] {
    SNP_IDLE    = 3'd0,
    SNP_SUPPLY0 = 3'd1,
    SNP_SUPPLY1 = 3'd2,
    SNP_WB0     = 3'd3,
    SNP_WB1     = 3'd4,
    SNP_UPDATE  = 3'd5,
    SNP_RELEASE = 3'd6
  } snoop_state_t;

  // An invalidating snoop drops the line; a plain read leaves it shared.
  function automatic msi_t downgrade(input logic inv);
    if (inv) begin
      return MSI_I;
    end else begin
      return MSI_S;
    end
  endfunction

endpackage

// File: rtl/dcache_snoop_responder_tag.sv
// dcache_tag_match: combinational 2-way tag compare for snoop lookups.
//   look_tag           in  tag field of the snooped address
//   way0_tag/way1_tag  in  stored tags of the indexed set
//   way0_msi/way1_msi  in  stored MSI state of the indexed set
//   hit                out some valid way matches
//   hit_way            out matching way (way0 preferred if both match)
//   hit_msi            out MSI state of the matching way (I on miss)
module dcache_tag_match
  import dcache_snoop_responder_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic [TAG_W-1:0] look_tag,
  input  logic [TAG_W-1:0] way0_tag,
  input  logic [TAG_W-1:0] way1_tag,
  input  logic [1:0]       way0_msi,
  input  logic [1:0]       way1_msi,
  output logic             hit,
  output logic             hit_way,
  output msi_t             hit_msi
);

  logic hit0_s;
  logic hit1_s;

  // Compare both ways; an I line never matches regardless of its stale tag.
  always_comb begin
    hit0_s = (way0_msi != MSI_I) && (way0_tag == look_tag);
    hit1_s = (way1_msi != MSI_I) && (way1_tag == look_tag);
    hit    = hit0_s | hit1_s;
    if (hit0_s) begin
      hit_way = 1'b0;
      hit_msi = msi_t'(way0_msi);
    end else if (hit1_s) begin
      hit_way = 1'b1;
      hit_msi = msi_t'(way1_msi);
    end else begin
      hit_way = 1'b0;
      hit_msi = MSI_I;
    end
  end

endmodule

// File: rtl/dcache_snoop_responder.sv
// dcache_snoop_responder: cache-side MSI snoop handler for one L1 dcache.
// Looks up snooped addresses in the dcache tag/state arrays; on an M hit it
// supplies the dirty 2-word block to the requester (BusRd only), writes it
// back to RAM and downgrades the line (M->S on BusRd, ->I on invalidate).
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   ccwait, ccinv, ccsnoopaddr snoop request from the bus controller
//   dwait                      RAM handshake for the writeback
//   ccwrite                    snoop hit a Modified line
//   snp_active                 dcache bus mux select (FSM not idle)
//   snp_dWEN/daddr/dstore      writeback / supplied data bus
//   snp_idx, way*_tag, way*_msi   array lookup
//   snp_rd_way/blk, snp_rd_data   data array read
//   st_we/way/idx/msi          MSI state write port
module dcache_snoop_responder
  import dcache_snoop_responder_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ccwait,
  input  logic             ccinv,
  input  logic [31:0]      ccsnoopaddr,
  input  logic             dwait,
  output logic             ccwrite,
  output logic             snp_active,
  output logic             snp_dWEN,
  output logic [31:0]      snp_daddr,
  output logic [31:0]      snp_dstore,
  output logic [IDX_W-1:0] snp_idx,
  input  logic [TAG_W-1:0] way0_tag,
  input  logic [TAG_W-1:0] way1_tag,
  input  logic [1:0]       way0_msi,
  input  logic [1:0]       way1_msi,
  output logic             snp_rd_way,
  output logic             snp_rd_blk,
  input  logic [31:0]      snp_rd_data,
  output logic             st_we,
  output logic             st_way,
  output logic [IDX_W-1:0] st_idx,
  output logic [1:0]       st_msi
);

  localparam int TI_W = TAG_W + IDX_W;

  snoop_state_t    state_q, state_d;
  logic [TI_W-1:0] ti_q, ti_d;          // latched {tag, idx} of the snooped block
  logic            inv_q, inv_d;
  logic            hit_q, hit_d;
  logic            hit_way_q, hit_way_d;
  msi_t            hit_msi_q, hit_msi_d;

  logic [TAG_W-1:0] look_tag_s;
  logic [IDX_W-1:0] look_idx_s;
  logic [IDX_W-1:0] idx_q_s;
  logic             m_hit_s;
  logic             m_way_s;
  msi_t             m_msi_s;
  logic             unused_addr_s;

  // Address bits above the tag field and the word/byte offsets are not
  // part of the lookup.
  assign look_tag_s    = ccsnoopaddr[IDX_LSB+IDX_W +: TAG_W];
  assign look_idx_s    = ccsnoopaddr[IDX_LSB +: IDX_W];
  assign idx_q_s       = ti_q[IDX_W-1:0];
  assign unused_addr_s = ^ccsnoopaddr;

  dcache_tag_match #(
    .TAG_W (TAG_W)
  ) u_tag_match (
    .look_tag (look_tag_s),
    .way0_tag (way0_tag),
    .way1_tag (way1_tag),
    .way0_msi (way0_msi),
    .way1_msi (way1_msi),
    .hit      (m_hit_s),
    .hit_way  (m_way_s),
    .hit_msi  (m_msi_s)
  );

  // State and latched snoop context registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= SNP_IDLE;
      ti_q      <= {TI_W{1'b0}};
      inv_q     <= 1'b0;
      hit_q     <= 1'b0;
      hit_way_q <= 1'b0;
      hit_msi_q <= MSI_I;
    end else begin
      state_q   <= state_d;
      ti_q      <= ti_d;
      inv_q     <= inv_d;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
      hit_msi_q <= hit_msi_d;
    end
  end

  // Next-state and context update.
  always_comb begin
    state_d   = state_q;
    ti_d      = ti_q;
    inv_d     = inv_q | ccinv;   // an invalidate seen at any point sticks
    hit_d     = hit_q;
    hit_way_d = hit_way_q;
    hit_msi_d = hit_msi_q;
    case (state_q)
      SNP_IDLE: begin
        if (ccwait) begin
          ti_d      = {look_tag_s, look_idx_s};
          inv_d     = ccinv;
          hit_d     = m_hit_s;
          hit_way_d = m_way_s;
          hit_msi_d = m_msi_s;
          if (m_hit_s && (m_msi_s == MSI_M)) begin
            state_d = ccinv ? SNP_WB0 : SNP_SUPPLY0;
          end else if (m_hit_s && (m_msi_s == MSI_S) && ccinv) begin
            state_d = SNP_UPDATE;
          end else begin
            state_d = SNP_RELEASE;
          end
        end else begin
          inv_d = 1'b0;
        end
      end
      SNP_SUPPLY0: begin
        state_d = ccwait ? SNP_SUPPLY1 : SNP_IDLE;
      end
      SNP_SUPPLY1: begin
        state_d = ccwait ? SNP_WB0 : SNP_IDLE;
      end
      SNP_WB0: begin
        if (!ccwait) begin
          state_d = SNP_IDLE;
        end else if (!dwait) begin
          state_d = SNP_WB1;
        end else begin
          state_d = SNP_WB0;
        end
      end
      SNP_WB1: begin
        // Once the second word is accepted the block is safe in RAM, so the
        // downgrade happens even if the controller lets go in that cycle.
        if (!dwait) begin
          state_d = SNP_UPDATE;
        end else if (!ccwait) begin
          state_d = SNP_IDLE;
        end else begin
          state_d = SNP_WB1;
        end
      end
      SNP_UPDATE: begin
        // Track the written state so a later invalidate in RELEASE knows
        // whether the line is still shared.
        hit_msi_d = downgrade(inv_q);
        state_d   = SNP_RELEASE;
      end
      SNP_RELEASE: begin
        if (ccinv && hit_q && (hit_msi_q == MSI_S)) begin
          state_d = SNP_UPDATE;
        end else if (!ccwait) begin
          state_d = SNP_IDLE;
        end else begin
          state_d = SNP_RELEASE;
        end
      end
      default: begin
        state_d = SNP_IDLE;
      end
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    ccwrite    = 1'b0;
    snp_active = (state_q != SNP_IDLE);
    snp_dWEN   = 1'b0;
    snp_daddr  = 32'd0;
    snp_dstore = 32'd0;
    snp_idx    = idx_q_s;
    snp_rd_way = 1'b0;
    snp_rd_blk = 1'b0;
    st_we      = 1'b0;
    st_way     = 1'b0;
    st_idx     = {IDX_W{1'b0}};
    st_msi     = MSI_I;
    case (state_q)
      SNP_IDLE: begin
        snp_idx = look_idx_s;
      end
      SNP_SUPPLY0: begin
        ccwrite    = 1'b1;
        snp_rd_way = hit_way_q;
        snp_rd_blk = 1'b0;
        snp_dstore = snp_rd_data;
      end
      SNP_SUPPLY1: begin
        ccwrite    = 1'b1;
        snp_rd_way = hit_way_q;
        snp_rd_blk = 1'b1;
        snp_dstore = snp_rd_data;
      end
      SNP_WB0: begin
        ccwrite    = 1'b1;
        snp_dWEN   = 1'b1;
        snp_rd_way = hit_way_q;
        snp_rd_blk = 1'b0;
        snp_daddr  = 32'({ti_q, 1'b0, 2'b00});
        snp_dstore = snp_rd_data;
      end
      SNP_WB1: begin
        ccwrite    = 1'b1;
        snp_dWEN   = 1'b1;
        snp_rd_way = hit_way_q;
        snp_rd_blk = 1'b1;
        snp_daddr  = 32'({ti_q, 1'b1, 2'b00});
        snp_dstore = snp_rd_data;
      end
      SNP_UPDATE: begin
        st_we  = 1'b1;
        st_way = hit_way_q;
        st_idx = idx_q_s;
        st_msi = downgrade(inv_q);
      end
      SNP_RELEASE: begin
        snp_idx = idx_q_s;
      end
      default: begin
        snp_idx = idx_q_s;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Scoreboard bench for dcache_snoop_responder: a small dcache array model
// answers lookups, a reference model predicts supplied words, writebacks and
// state updates per snoop, and a monitor checks them as the DUT presents them.
module tb_dcache_snoop_responder;

  localparam int IDX_W = 3;
  localparam int TAG_W = 25;
  localparam logic [1:0] L_I = 2'b00;
  localparam logic [1:0] L_S = 2'b01;
  localparam logic [1:0] L_M = 2'b10;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ccwait, ccinv, dwait;
  logic [31:0]      ccsnoopaddr;
  logic             ccwrite, snp_active, snp_dWEN;
  logic [31:0]      snp_daddr, snp_dstore;
  logic [IDX_W-1:0] snp_idx;
  logic [TAG_W-1:0] way0_tag, way1_tag;
  logic [1:0]       way0_msi, way1_msi;
  logic             snp_rd_way, snp_rd_blk;
  logic [31:0]      snp_rd_data;
  logic             st_we, st_way;
  logic [IDX_W-1:0] st_idx;
  logic [1:0]       st_msi;

  dcache_snoop_responder #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .ccwrite(ccwrite),
    .snp_active(snp_active), .snp_dWEN(snp_dWEN), .snp_daddr(snp_daddr),
    .snp_dstore(snp_dstore), .snp_idx(snp_idx), .way0_tag(way0_tag),
    .way1_tag(way1_tag), .way0_msi(way0_msi), .way1_msi(way1_msi),
    .snp_rd_way(snp_rd_way), .snp_rd_blk(snp_rd_blk), .snp_rd_data(snp_rd_data),
    .st_we(st_we), .st_way(st_way), .st_idx(st_idx), .st_msi(st_msi)
  );

  always #5 CLK = ~CLK;

  // dcache arrays seen by the DUT; msi_a is written only here.
  logic [TAG_W-1:0] tag_a   [0:7][0:1];
  logic [31:0]      dat_a   [0:7][0:1][0:1];
  logic [1:0]       msi_a   [0:7][0:1];
  logic [1:0]       ref_msi [0:7][0:1];
  logic             fill = 1'b0;

  always @(posedge CLK) begin
    if (fill) msi_a <= ref_msi;
    else if (nRST === 1'b1 && st_we === 1'b1) msi_a[st_idx][st_way] <= st_msi;
  end

  assign way0_tag    = tag_a[snp_idx][0];
  assign way1_tag    = tag_a[snp_idx][1];
  assign way0_msi    = msi_a[snp_idx][0];
  assign way1_msi    = msi_a[snp_idx][1];
  assign snp_rd_data = dat_a[snp_idx][snp_rd_way][snp_rd_blk];

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wb_t;
  logic [31:0] sup_q[$];
  wb_t         wb_q[$];
  logic [5:0]  st_q[$];   // {way, idx, msi}

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Two valid ways carrying the same tag is an illegal array state.
  always @(negedge CLK) begin
    if (nRST === 1'b1)
      assert (!(way0_msi != L_I && way1_msi != L_I && way0_tag == way1_tag))
        else $error("illegal dual tag match at idx %0d", snp_idx);
  end

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (ccwrite && !snp_dWEN) begin
        chk("supply_pending", 32'(sup_q.size() != 0), 32'd1);
        if (sup_q.size() != 0) begin
          chk("supply_word", snp_dstore, sup_q[0]);
          void'(sup_q.pop_front());
        end
      end
      if (snp_dWEN) begin
        chk("wb_pending", 32'(wb_q.size() != 0), 32'd1);
        chk("ccwrite_in_wb", 32'(ccwrite), 32'd1);
        if (wb_q.size() != 0) begin
          chk("wb_addr", snp_daddr, wb_q[0].a);
          chk("wb_data", snp_dstore, wb_q[0].d);
          if (!dwait) void'(wb_q.pop_front());
        end
      end
      if (st_we) begin
        chk("st_pending", 32'(st_q.size() != 0), 32'd1);
        if (st_q.size() != 0) begin
          chk("st_update", {26'd0, st_way, st_idx, st_msi}, {26'd0, st_q[0]});
          void'(st_q.pop_front());
        end
      end
    end
  end

  // Reference model: what one snoop must produce, and the line's new state.
  task automatic expect_snoop(input logic [31:0] addr, input bit inv, output bit mh, output int way);
    logic [2:0]       idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      base;
    idx  = addr[5:3];
    tag  = addr[30:6];
    base = {1'b0, tag, idx, 3'b000};
    way  = -1;
    for (int w = 0; w < 2; w++)
      if (way < 0 && ref_msi[idx][w] != L_I && tag_a[idx][w] == tag) way = w;
    mh = (way >= 0) && (ref_msi[idx][way] == L_M);
    if (mh) begin
      if (!inv) begin
        sup_q.push_back(dat_a[idx][way][0]);
        sup_q.push_back(dat_a[idx][way][1]);
      end
      wb_q.push_back('{a: base,         d: dat_a[idx][way][0]});
      wb_q.push_back('{a: base + 32'd4, d: dat_a[idx][way][1]});
      ref_msi[idx][way] = inv ? L_I : L_S;
      st_q.push_back({1'(way), idx, ref_msi[idx][way]});
    end else if (way >= 0 && ref_msi[idx][way] == L_S && inv) begin
      ref_msi[idx][way] = L_I;
      st_q.push_back({1'(way), idx, L_I});
    end
  endtask

  // Called at a negedge; returns at the negedge where the responder is parked.
  task automatic wait_release();
    int n = 0;
    while (!(snp_active && !ccwrite && !st_we) && n < 60) begin
      @(posedge CLK); #1 dwait = 1'($urandom_range(0, 1));
      @(negedge CLK);
      n++;
    end
    chk("release_reached", 32'(n < 60), 32'd1);
  endtask

  task automatic do_snoop(input logic [31:0] addr, input bit inv, input bit rel_inv);
    bit         mh;
    int         way;
    logic [2:0] idx;
    idx = addr[5:3];
    expect_snoop(addr, inv, mh, way);
    @(posedge CLK); #1;
    ccsnoopaddr = addr; ccinv = inv; ccwait = 1'b1; dwait = 1'($urandom_range(0, 1));
    @(posedge CLK); @(negedge CLK);
    chk("ccwrite_first_cycle", 32'(ccwrite), 32'(mh));
    wait_release();
    if (rel_inv && way >= 0 && ref_msi[idx][way] == L_S) begin
      ref_msi[idx][way] = L_I;
      st_q.push_back({1'(way), idx, L_I});
      @(posedge CLK); #1 ccinv = 1'b1;
      @(posedge CLK); #1 ccinv = 1'b0;
      @(negedge CLK);
      wait_release();
    end
    @(posedge CLK); #1 ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("idle_after_release", 32'(snp_active), 32'd0);
    chk("queues_drained", 32'(sup_q.size() + wb_q.size() + st_q.size()), 32'd0);
  endtask

  task automatic refill();
    @(posedge CLK); #1 fill = 1'b1;
    @(posedge CLK); #1 fill = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {20'd0, ccwrite, snp_active, snp_dWEN, st_we, st_way,
                       snp_rd_way, snp_rd_blk, st_msi, st_idx}, 32'd0);
    chk({nm, "_daddr"}, snp_daddr, 32'd0);
    chk({nm, "_dstore"}, snp_dstore, 32'd0);
  endtask

  // ccwait dropped while the first writeback word is stalled.
  task automatic abort_wb0(input logic [2:0] idx);
    logic [31:0] base;
    base = {1'b0, tag_a[idx][0], idx, 3'b000};
    wb_q.push_back('{a: base,         d: dat_a[idx][0][0]});
    wb_q.push_back('{a: base + 32'd4, d: dat_a[idx][0][1]});
    @(posedge CLK); #1 ccsnoopaddr = base; ccinv = 1'b1; ccwait = 1'b1; dwait = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("abort_wb0_dwen", 32'(snp_dWEN), 32'd1);
    @(posedge CLK); #1 ccwait = 1'b0; ccinv = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("abort_idle", {30'd0, snp_active, snp_dWEN}, 32'd0);
    repeat (3) begin
      @(negedge CLK);
      chk("abort_no_st_we", 32'(st_we), 32'd0);
    end
    wb_q.delete();
    dwait = 1'b0;
  endtask

  // Async reset while the second writeback word is stalled.
  task automatic reset_wb1(input logic [2:0] idx);
    logic [31:0] base;
    base = {1'b0, tag_a[idx][1], idx, 3'b000};
    wb_q.push_back('{a: base,         d: dat_a[idx][1][0]});
    wb_q.push_back('{a: base + 32'd4, d: dat_a[idx][1][1]});
    @(posedge CLK); #1 ccsnoopaddr = base; ccinv = 1'b1; ccwait = 1'b1; dwait = 1'b0;
    @(posedge CLK); @(posedge CLK); #1 dwait = 1'b1;
    @(negedge CLK);
    chk("rst_wb1_addr", snp_daddr, base + 32'd4);
    #1 nRST = 1'b0;
    #1 chk_zero("rst_mid_wb");
    ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    wb_q.delete();
    @(negedge CLK);
    chk("rst_wb1_idle", 32'(snp_active), 32'd0);
  endtask

  // ccwait falls in the same cycle WB1 is accepted: the update still happens.
  task automatic drop_at_wb1(input logic [2:0] idx);
    logic [31:0] base;
    base = {1'b0, tag_a[idx][0], idx, 3'b000};
    wb_q.push_back('{a: base,         d: dat_a[idx][0][0]});
    wb_q.push_back('{a: base + 32'd4, d: dat_a[idx][0][1]});
    ref_msi[idx][0] = L_I;
    st_q.push_back({1'b0, idx, L_I});
    @(posedge CLK); #1 ccsnoopaddr = base; ccinv = 1'b1; ccwait = 1'b1; dwait = 1'b0;
    @(posedge CLK); @(posedge CLK); #1 dwait = 1'b1;
    @(negedge CLK);
    chk("drop_wb1_addr", snp_daddr, base + 32'd4);
    @(posedge CLK); #1 dwait = 1'b0; ccwait = 1'b0; ccinv = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("drop_wb1_st_we", 32'(st_we), 32'd1);
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    chk("drop_wb1_idle", 32'(snp_active), 32'd0);
    chk("drop_wb1_drained", 32'(wb_q.size() + st_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TAG_W-1:0] t;
    logic [2:0]       idx;
    int               sel, w;

    for (int i = 0; i < 8; i++) begin
      tag_a[i][0] = 25'($urandom_range(0, 24'hFFFFFF));
      tag_a[i][1] = 25'($urandom_range(0, 24'hFFFFFF));
      if (tag_a[i][1] == tag_a[i][0]) tag_a[i][1] = tag_a[i][0] ^ 25'd1;
      for (int j = 0; j < 2; j++) begin
        ref_msi[i][j]  = 2'($urandom_range(0, 2));
        dat_a[i][j][0] = $urandom;
        dat_a[i][j][1] = $urandom;
      end
    end
    tag_a[3][1] = 25'h1234; ref_msi[3][1] = L_M;
    dat_a[3][1][0] = 32'hDEADBEEF; dat_a[3][1][1] = 32'hCAFEF00D;
    tag_a[3][0] = 25'h55;   ref_msi[3][0] = L_S;

    // Reset: outputs zero and ccwait ignored while nRST is low.
    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b0; ccsnoopaddr = 32'd0;
    fill = 1'b1;
    @(posedge CLK); #1 fill = 1'b0;
    chk_zero("reset");
    chk("reset_idx", 32'(snp_idx), 32'd0);
    ccsnoopaddr = 32'h00048D18; ccwait = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_zero("reset_ccwait");
    @(posedge CLK); #1 ccwait = 1'b0;
    #1 nRST = 1'b1;

    // Directed: BusRd M-hit, invalidate S-hit, BusRdX M-hit, miss, BusRd S-hit.
    do_snoop(32'h00048D18, 1'b0, 1'b0);
    do_snoop(32'h00048D18, 1'b1, 1'b0);
    ref_msi[3][1] = L_M;
    refill();
    do_snoop(32'h00048D18, 1'b1, 1'b0);
    do_snoop({1'b0, 25'h1000ABC, 3'd3, 3'd0}, 1'b0, 1'b0);
    do_snoop({1'b0, 25'h55, 3'd3, 3'd4}, 1'b0, 1'b1);

    // Aborts and the late-drop corner.
    ref_msi[5][0] = L_M; ref_msi[6][1] = L_M; ref_msi[2][0] = L_M;
    refill();
    abort_wb0(3'd5);
    reset_wb1(3'd6);
    drop_at_wb1(3'd2);

    // Random snoops, reseeding line states now and then.
    for (int n = 0; n < 40; n++) begin
      idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom_range(0, 1);
        ref_msi[idx][w] = 2'($urandom_range(0, 2));
        refill();
      end
      sel = $urandom_range(0, 2);
      t = (sel == 2) ? {1'b1, 24'($urandom)} : tag_a[idx][sel];
      do_snoop({1'b0, t, idx, 3'($urandom_range(0, 7))},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 2; j++)
        chk("final_msi", 32'(msi_a[i][j]), 32'(ref_msi[i][j]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
